// File: rtl/dffram_bist_ctrl_pkg.sv
// dffram_bist_pkg: shared FSM encoding, phase enum, status codes, seeds and the test pattern for the DFFRAM BIST
package dffram_bist_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_PASS  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_FAIL  = 3'd6;
  typedef enum logic [1:0] {PH_WORD, PH_HALF, PH_BYTE} phase_e;
  localparam logic [31:0] SEED_WORD = 32'h5555_AAAA;
  localparam logic [31:0] SEED_HALF = 32'h3C3C_C3C3;
  localparam logic [31:0] SEED_BYTE = 32'h0F0F_F0F0;
  localparam logic [15:0] ST_IDLE       = 16'h0000;
  localparam logic [15:0] ST_WORD_START = 16'hA040;
  localparam logic [15:0] ST_WORD_PASS  = 16'hAB41;
  localparam logic [15:0] ST_WORD_FAIL  = 16'hAB40;
  localparam logic [15:0] ST_HALF_START = 16'hA020;
  localparam logic [15:0] ST_HALF_PASS  = 16'hAB21;
  localparam logic [15:0] ST_HALF_FAIL  = 16'hAB20;
  localparam logic [15:0] ST_BYTE_START = 16'hA010;
  localparam logic [15:0] ST_BYTE_PASS  = 16'hAB11;
  localparam logic [15:0] ST_BYTE_FAIL  = 16'hAB10;
  localparam logic [15:0] ST_DONE       = ST_BYTE_PASS;
  function automatic logic [31:0] seed_of(input phase_e p);
    return p == PH_WORD ? SEED_WORD : p == PH_HALF ? SEED_HALF : SEED_BYTE;
  endfunction
  function automatic logic [31:0] pattern(input logic [7:0] a8, input logic [31:0] seed);
    return {~a8, a8, ~a8, a8} ^ seed;
  endfunction
  function automatic logic [1:0] sub_max(input phase_e p);
    return p == PH_WORD ? 2'd0 : p == PH_HALF ? 2'd1 : 2'd3;
  endfunction
  function automatic logic [3:0] lane_we(input phase_e p, input logic [1:0] sub);
    return p == PH_WORD ? 4'hF : p == PH_HALF ? (sub[0] ? 4'hC : 4'h3) : 4'b0001 << sub;
  endfunction
  function automatic logic [15:0] code_start(input phase_e p);
    return p == PH_WORD ? ST_WORD_START : p == PH_HALF ? ST_HALF_START : ST_BYTE_START;
  endfunction
  function automatic logic [15:0] code_pass(input phase_e p);
    return p == PH_WORD ? ST_WORD_PASS : p == PH_HALF ? ST_HALF_PASS : ST_BYTE_PASS;
  endfunction
  function automatic logic [15:0] code_fail(input phase_e p);
    return p == PH_WORD ? ST_WORD_FAIL : p == PH_HALF ? ST_HALF_FAIL : ST_BYTE_FAIL;
  endfunction
endpackage

// File: rtl/dffram_bist_ctrl_if.sv
// dffram_bist_ctrl_if: host RAM port plus DFFRAM port seen by the BIST controller
//   host_en/host_we/host_a/host_di -> controller, host_do/host_stall <- controller
//   ram_en/ram_we/ram_a/ram_di <- controller, ram_do -> controller (valid one cycle after a read)
//   slave: controller side, master: SoC/RAM side
interface dffram_bist_ctrl_if #(parameter int ADDR_W = 8);
  logic              host_en;
  logic [3:0]        host_we;
  logic [ADDR_W-1:0] host_a;
  logic [31:0]       host_di;
  logic [31:0]       host_do;
  logic              host_stall;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [31:0]       ram_di;
  logic [31:0]       ram_do;
  modport slave (
    input  host_en, host_we, host_a, host_di, ram_do,
    output host_do, host_stall, ram_en, ram_we, ram_a, ram_di
  );
  modport master (
    output host_en, host_we, host_a, host_di, ram_do,
    input  host_do, host_stall, ram_en, ram_we, ram_a, ram_di
  );
endinterface

// File: rtl/dffram_bist_ctrl_port_mux.sv
// dffram_port_mux: hands the DFFRAM port to the host when idle and to the BIST engine while busy
//   busy            controller owns the RAM
//   ctl_en/we/a/di  controller request, ctl_do read data back to the controller
//   bus             host and RAM ports
module dffram_port_mux #(parameter int ADDR_W = 8) (
  input  logic              busy,
  input  logic              ctl_en,
  input  logic [3:0]        ctl_we,
  input  logic [ADDR_W-1:0] ctl_a,
  input  logic [31:0]       ctl_di,
  output logic [31:0]       ctl_do,
  dffram_bist_ctrl_if.slave bus
);
  assign bus.ram_en     = busy ? ctl_en : bus.host_en;
  assign bus.ram_we     = busy ? ctl_we : bus.host_we;
  assign bus.ram_a      = busy ? ctl_a  : bus.host_a;
  assign bus.ram_di     = busy ? ctl_di : bus.host_di;
  assign bus.host_do    = busy ? 32'h0  : bus.ram_do;
  assign bus.host_stall = busy & bus.host_en;
  assign ctl_do         = bus.ram_do;
endmodule

// File: rtl/dffram_bist_ctrl.sv
// dffram_bist_ctrl: write/read-back BIST for a 2^ADDR_W x 32 DFFRAM in word, half-word and byte write phases
//   core_clk/core_rstn   clock, asynchronous active-low reset
//   start                one-cycle run request, ignored while a test is running
//   busy/done/pass       running / finished / finished without miscompare
//   status               progress code for la_output[31:16]
//   fail_addr/fail_data  first miscompare, captured only when DFFRAM_BIST_FAIL_CAPTURE_EN is defined
//   bus                  host and DFFRAM ports (slave modport)
module dffram_bist_ctrl
  import dffram_bist_pkg::*;
#(parameter int ADDR_W = 8) (
  input  logic              core_clk,
  input  logic              core_rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       status,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [31:0]       fail_data,
  dffram_bist_ctrl_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  logic [2:0]        state;
  phase_e            phase;
  logic [ADDR_W-1:0] addr, rd_addr;
  logic [1:0]        sub;
  logic              rd_vld, go, mis, last_sub, c_en;
  logic [3:0]        c_we;
  logic [31:0]       seed, c_di, c_do;
  always_comb begin
    seed     = seed_of(phase);
    last_sub = sub == sub_max(phase);
    go       = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
    // read data lags the address by one cycle, so compare against the registered address
    mis      = rd_vld && (state == S_RD || state == S_FLUSH) && c_do != pattern(8'(rd_addr), seed);
    busy     = state == S_WR || state == S_RD || state == S_FLUSH || state == S_PASS;
    done     = state == S_DONE || state == S_FAIL;
    pass     = state == S_DONE;
    status   = state == S_IDLE ? ST_IDLE :
               state == S_PASS ? code_pass(phase) :
               state == S_FAIL ? code_fail(phase) :
               state == S_DONE ? ST_DONE : code_start(phase);
    c_en     = state == S_WR || state == S_RD;
    c_we     = state == S_WR ? lane_we(phase, sub) : 4'h0;
    c_di     = pattern(8'(addr), seed);
  end
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state   <= S_IDLE;
      phase   <= PH_WORD;
      addr    <= '0;
      sub     <= '0;
      rd_vld  <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_vld  <= state == S_RD;
      rd_addr <= addr;
      if (go) begin
        state <= S_WR;
        phase <= PH_WORD;
        addr  <= '0;
        sub   <= '0;
      end else begin
        case (state)
          S_WR: begin
            sub <= last_sub ? 2'd0 : sub + 2'd1;
            if (last_sub) begin
              addr  <= addr == LAST ? '0 : addr + 1'b1;
              state <= addr == LAST ? S_RD : S_WR;
            end
          end
          S_RD: begin
            if (mis) state <= S_FAIL;
            else begin
              addr  <= addr == LAST ? '0 : addr + 1'b1;
              state <= addr == LAST ? S_FLUSH : S_RD;
            end
          end
          S_FLUSH: state <= mis ? S_FAIL : S_PASS;
          S_PASS: begin
            state <= phase == PH_BYTE ? S_DONE : S_WR;
            phase <= phase == PH_WORD ? PH_HALF : PH_BYTE;
          end
          default: ;
        endcase
      end
    end
  end
`ifdef DFFRAM_BIST_FAIL_CAPTURE_EN
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (go) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (mis) begin
      fail_addr <= rd_addr;
      fail_data <= c_do;
    end
  end
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif
  dffram_port_mux #(.ADDR_W(ADDR_W)) u_mux (
    .busy   (busy),
    .ctl_en (c_en),
    .ctl_we (c_we),
    .ctl_a  (addr),
    .ctl_di (c_di),
    .ctl_do (c_do),
    .bus    (bus)
  );
endmodule

// File: doc/dffram_bist_ctrl.md
DFFRAM_BIST_CTRL -- requirements
Module: dffram_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, RAM word-address width; N = 2^ADDR_W words.
REQ-002 core_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 core_rstn  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  single-cycle request to run the full test.
REQ-005 busy / done / pass  out  1 each  test running / test finished / finished without miscompare.
REQ-006 status  out  16  progress code, for driving la_output[31:16].
REQ-007 fail_addr  out  ADDR_W, fail_data  out  32  first miscompare address and read data.
REQ-008 host_en, host_we[3:0], host_a[ADDR_W-1:0], host_di[31:0]  in; host_do[31:0], host_stall  out  host RAM port.
REQ-009 ram_en, ram_we[3:0], ram_a, ram_di[31:0]  out; ram_do[31:0]  in  DFFRAM port; read data valid one cycle after ram_en with ram_we=0.

Function
REQ-010 States: IDLE, WR, RD, FLUSH, PASS, DONE, FAIL; phases WORD, HALF, BYTE in that order.
REQ-011 IDLE: start=1 enters WR of WORD on the next edge; start while not IDLE is ignored.
REQ-012 Pattern P(a) = {~a8, a8, ~a8, a8} XOR SEED, a8 = address zero-extended/truncated to 8 bits; SEED: WORD 32'h5555_AAAA, HALF 32'h3C3C_C3C3, BYTE 32'h0F0F_F0F0.
REQ-013 WR: addresses 0..N-1 ascending, W writes per address with ram_di=P(a); WORD we=1111; HALF we=0011 then 1100; BYTE we=0001,0010,0100,1000.
REQ-014 RD: addresses 0..N-1 ascending, one read per cycle, ram_we=0000; ram_do compared to P(a-1) the following cycle; FLUSH compares the final word.
REQ-015 Phase length: W*N + N + 1 cycles, then one PASS cycle; status = phase start code throughout WR/RD/FLUSH, pass code during PASS.
REQ-016 Codes: WORD start/pass/fail 16'hA040/16'hAB41/16'hAB40; HALF 16'hA020/16'hAB21/16'hAB20; BYTE 16'hA010/16'hAB11/16'hAB10; IDLE 16'h0000.
REQ-017 Miscompare: next edge enters FAIL; ram_en=0; status = phase fail code; done=1, pass=0, busy=0; held until next start.
REQ-018 After BYTE PASS: DONE, status 16'hAB11, done=1, pass=1, held until next start; start from DONE/FAIL clears done and restarts.
REQ-019 Total: done first high 10N+7 cycles after the start-sampling edge.
REQ-020 Arbitration: busy=0 -> host_* passed combinationally to ram_*, ram_do to host_do, host_stall=0; busy=1 -> controller owns RAM, host_stall=host_en, host writes discarded, host_do=0.
REQ-021 Address counter never wraps: final address N-1 terminates the pass.

Reset
REQ-022 core_rstn low: immediately IDLE, busy=done=pass=0, status=0, fail_addr=0, fail_data=0, RAM released to host, even mid-test.
REQ-023 No pending RAM write is completed after reset assertion.

Configuration
REQ-024 Macro DFFRAM_BIST_FAIL_CAPTURE_EN defined: fail_addr/fail_data latched on the first miscompare, held until next start.
REQ-025 Macro undefined: fail_addr and fail_data tied to zero, no capture registers; all other behaviour identical.

Structure
REQ-026 Package dffram_bist_pkg: state and phase enums, status code constants, seed constants, pattern function.
REQ-027 One sub-module dffram_port_mux implements the REQ-020 host/controller multiplexer.

Verification
REQ-028 ADDR_W=4, fault-free RAM, start pulse -> status A040,AB41,A020,AB21,A010,AB11; done=1 pass=1 at cycle 167.
REQ-029 Bit 5 of word 3 stuck-at-0 -> status AB40, fail_addr=3, fail_data bit 5 =0, done=1 pass=0, no further ram_en.
REQ-030 Lane-2 write ignored for we=0100 only -> WORD, HALF pass; status AB10 at address 0.
REQ-031 Host write 0xDEADBEEF to addr 2 in IDLE then read -> host_do=0xDEADBEEF next cycle; same write while busy -> host_stall=1, RAM unchanged.
REQ-032 core_rstn low mid-HALF RD -> status 0, busy 0 same cycle; re-start completes with pass=1.
REQ-033 start pulsed during WORD WR -> ignored, cycle count to done unchanged.
